// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU with registered result and flags
//
// Accepts one operation per in_valid/in_ready handshake and presents the
// registered result on out_valid/out_ready. Logic, add/sub, SLT and illegal
// opcodes complete in one cycle; shifts iterate SHIFT_STEP bits per cycle.
// Optional iterative multiply (opcode 1011) is built when ALU_SEQ_MUL_EN is
// defined; otherwise that opcode is reported as illegal.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid, in_ready    operation handshake
//   a, b                  operands (shift amount is b[SHW-1:0])
//   alucont, sltunsigned  opcode, unsigned select for SLT
//   out_valid, out_ready  result handshake
//   result                registered result
//   zero                  a == b for the accepted operation
//   overflow              signed overflow for ADD/SUB
//   illegal               opcode not supported
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucont,
    input  logic             sltunsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] STEP = SHW'(SHIFT_STEP);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, ill_q;
    logic [SHW-1:0]   rem_q;
    logic [1:0]       sh_kind_q;   // alucont[1:0]: 00 SLL, 01 SRL, 10 SRA

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q, mplier_q;
    logic [SHW-1:0]   cnt_q;
`endif

    logic accept;
    assign in_ready  = reset_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    // Shared adder: SUB is a + ~b + 1.
    logic             sub_op;
    logic [WIDTH-1:0] b_eff, sum;
    assign sub_op = (alucont == OP_SUB);
    assign b_eff  = sub_op ? ~b : b;
    assign sum    = a + b_eff + {{(WIDTH-1){1'b0}}, sub_op};

    // One extra bit keeps the sign of the difference exact for both
    // signed and unsigned comparisons.
    logic [WIDTH:0] a_ext, b_ext, diff;
    assign a_ext = {~sltunsigned & a[WIDTH-1], a};
    assign b_ext = {~sltunsigned & b[WIDTH-1], b};
    assign diff  = a_ext - b_ext;

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf, alu_ill, is_shift, is_mul;

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        is_mul   = 1'b0;
        case (alucont)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub_op) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            OP_SLL, OP_SRL, OP_SRA: begin
                is_shift = 1'b1;
                alu_res  = a;   // working value; also the answer when shamt == 0
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    logic [SHW-1:0] step_now, rem_next;
    assign step_now = (rem_q < STEP) ? rem_q : STEP;
    assign rem_next = rem_q - step_now;

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SHIFT: if (rem_next == '0) state_d = S_DONE;
`ifdef ALU_SEQ_MUL_EN
            S_MUL:   if (cnt_q == SHW'(WIDTH-1)) state_d = S_DONE;
`endif
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new operation overrides the DONE->IDLE return.
        if (accept) begin
            if (is_mul)                        state_d = S_MUL;
            else if (is_shift && shamt != '0)  state_d = S_SHIFT;
            else                               state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
            rem_q     <= '0;
            sh_kind_q <= 2'b00;
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else if (accept) begin
            result_q  <= alu_res;
            zero_q    <= ~|(a ^ b);
            ovf_q     <= alu_ovf;
            ill_q     <= alu_ill;
            rem_q     <= shamt;
            sh_kind_q <= alucont[1:0];
`ifdef ALU_SEQ_MUL_EN
            mcand_q   <= a;
            mplier_q  <= b;
            cnt_q     <= '0;
`endif
        end else if (state_q == S_SHIFT) begin
            // SRA keeps the original sign bit because the working register's
            // MSB is never changed by an arithmetic right shift.
            case (sh_kind_q)
                2'b00:   result_q <= result_q << step_now;
                2'b01:   result_q <= result_q >> step_now;
                default: result_q <= $signed(result_q) >>> step_now;
            endcase
            rem_q <= rem_next;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_q == S_MUL) begin
            if (mplier_q[0]) result_q <= result_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
`endif
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset_n, in_valid, out_ready, sltunsigned;
    logic [31:0] a, b;
    logic [3:0]  alucont;
    logic        in_ready, out_valid, zero, overflow, illegal;
    logic [31:0] result;
    logic        in_ready4, out_valid4, zero4, overflow4, illegal4;
    logic [31:0] result4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alucont(alucont), .sltunsigned(sltunsigned),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .alucont(alucont), .sltunsigned(sltunsigned),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
        .zero(zero4), .overflow(overflow4), .illegal(illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the main DUT and wait (bounded) for its result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic su, output logic [31:0] r, output int lat,
                         output logic z, output logic ov, output logic il);
        alucont = op; a = av; b = bv; sltunsigned = su; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        r = result; z = zero; ov = overflow; il = illegal;
    endtask

    logic [31:0] r, r1, r4;
    logic        z, ov, il;
    int          lat, lat1, lat4, lowcnt, vcnt;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alucont = '0; sltunsigned = 1'b0;
        tick(); tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'b0, zero, overflow, illegal}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        do_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r, lat, z, ov, il);
        check("add_lat", lat, 32'd1);
        check("add_res", r, 32'h8000_0000);
        check("add_ovf", {31'b0, ov}, 32'd1);
        check("add_zero", {31'b0, z}, 32'd0);

        do_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 1'b0, r, lat, z, ov, il);
        check("sub_res", r, 32'h7FFF_FFFF);
        check("sub_ovf", {31'b0, ov}, 32'd1);

        do_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, r, lat, z, ov, il);
        check("and_res", r, 32'hF000_F000);
        do_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, r, lat, z, ov, il);
        check("or_res", r, 32'hFFF0_FFF0);

        do_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, lat, z, ov, il);
        check("slt_signed", r, 32'd1);
        check("slt_ovf", {31'b0, ov}, 32'd0);
        do_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, r, lat, z, ov, il);
        check("slt_unsigned", r, 32'd0);

        // SRA by 31 on both step widths at once
        alucont = 4'b1010; a = 32'h8000_0000; b = 32'd31; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat1 = 0; lat4 = 0; lowcnt = 0; r1 = '0; r4 = '0;
        for (int n = 1; n < 200 && (lat1 == 0 || lat4 == 0); n++) begin
            if (lat1 == 0 && !out_valid && !in_ready) lowcnt++;
            if (out_valid && lat1 == 0) begin lat1 = n; r1 = result; end
            if (out_valid4 && lat4 == 0) begin lat4 = n; r4 = result4; end
            if (lat1 == 0 || lat4 == 0) tick();
        end
        check("sra_lat_step1", lat1, 32'd32);
        check("sra_busy_cycles", lowcnt, 32'd31);
        check("sra_res_step1", r1, 32'hFFFF_FFFF);
        check("sra_lat_step4", lat4, 32'd9);
        check("sra_res_step4", r4, 32'hFFFF_FFFF);

        do_op(4'b1000, 32'h0000_0001, 32'd4, 1'b0, r, lat, z, ov, il);
        check("sll_lat", lat, 32'd5);
        check("sll_res", r, 32'h0000_0010);
        do_op(4'b1001, 32'h8000_0000, 32'd4, 1'b0, r, lat, z, ov, il);
        check("srl_res", r, 32'h0800_0000);
        do_op(4'b1001, 32'h1234_5678, 32'h0000_0100, 1'b0, r, lat, z, ov, il);
        check("shift0_lat", lat, 32'd1);
        check("shift0_res", r, 32'h1234_5678);

        // back-to-back SUB then XOR with in_valid held
        alucont = 4'b0110; a = 32'd5; b = 32'd5; in_valid = 1'b1;
        tick();
        check("b2b_sub_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_sub_res", result, 32'd0);
        check("b2b_sub_zero", {31'b0, zero}, 32'd1);
        alucont = 4'b0100; a = 32'hF0; b = 32'hFF;
        tick();
        check("b2b_xor_valid", {31'b0, out_valid}, 32'd1);
        check("b2b_xor_res", result, 32'h0F);
        check("b2b_xor_zero", {31'b0, zero}, 32'd0);
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_res", result, 32'h0F);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // reset in the middle of a shift
        alucont = 4'b1000; a = 32'd1; b = 32'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_res", result, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("abort_idle_ready", {31'b0, in_ready}, 32'd1);
        vcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check("abort_no_stale", vcnt, 32'd0);

        do_op(4'b1111, 32'd9, 32'd9, 1'b0, r, lat, z, ov, il);
        check("ill_res", r, 32'd0);
        check("ill_flag", {31'b0, il}, 32'd1);
        check("ill_zero", {31'b0, z}, 32'd1);

        do_op(4'b1011, 32'd7, 32'd6, 1'b0, r, lat, z, ov, il);
`ifdef ALU_SEQ_MUL_EN
        check("mul_lat", lat, 32'd33);
        check("mul_res", r, 32'd42);
        check("mul_ill", {31'b0, il}, 32'd0);
`else
        check("mul_lat", lat, 32'd1);
        check("mul_res", r, 32'd0);
        check("mul_ill", {31'b0, il}, 32'd1);
`endif
        check("mul_ovf", {31'b0, ov}, 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
